// File: rtl/weighted_bus_arbiter.sv
// Weighted round-robin arbiter: shares one RAM server port among NR_OF_CLIENTS rq/ack
// clients and aborts any server transaction that stays unacknowledged for TIMEOUT_CYCLES.
module weighted_bus_arbiter #(
  parameter int          DATA_WIDTH     = 8,
  parameter int          ADDR_WIDTH     = 4,
  parameter int          NR_OF_CLIENTS  = 4,
  parameter logic [31:0] CLIENT_WEIGHTS = 32'h0000_4211,
  parameter int          TIMEOUT_CYCLES = 15
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NR_OF_CLIENTS-1:0]            client_rq,
  input  logic [NR_OF_CLIENTS*ADDR_WIDTH-1:0] client_address,
  input  logic [NR_OF_CLIENTS-1:0]            client_wr_ni,
  input  logic [NR_OF_CLIENTS*DATA_WIDTH-1:0] client_dataW,
  output logic [NR_OF_CLIENTS-1:0]            client_ack,
  output logic [NR_OF_CLIENTS-1:0]            client_err,
  output logic [DATA_WIDTH-1:0]               client_dataR,
  output logic [ADDR_WIDTH-1:0]               server_address,
  output logic                                server_rq,
  output logic                                server_wr_ni,
  output logic [DATA_WIDTH-1:0]               server_dataW,
  input  logic                                server_ack,
  input  logic [DATA_WIDTH-1:0]               server_dataR,
  output logic [2:0]                          grant_id,
  output logic                                busy
);

  // Handshake: a client raises rq with stable address/wr_ni/dataW and holds them until it
  // sees its one-cycle ack; the server side sees rq held for the whole GRANT and answers
  // with a one-cycle server_ack, which completes the transaction in that same cycle.

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0] LAST_CLIENT  = 3'(NR_OF_CLIENTS - 1);

  state_e          state_q, state_d;
  logic [2:0]      grant_id_q, grant_id_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [3:0]      credit_q, credit_d;
  logic [7:0]      timer_q, timer_d;

  logic            hi_found, lo_found;
  logic [2:0]      hi_win, lo_win, winner, rot_ptr;
  logic            done, timeout;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic            sel_wr;
  logic [DATA_WIDTH-1:0] sel_data;

  function automatic logic [3:0] weight_of(input logic [2:0] idx);
    logic [3:0] w;
    w = CLIENT_WEIGHTS[{idx, 2'b00} +: 4];
    return (w == 4'd0) ? 4'd1 : w;
  endfunction

  // Cyclic scan from ptr: first requester at or above ptr, else lowest requester overall.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_win   = '0;
    lo_win   = '0;
    for (int c = 0; c < NR_OF_CLIENTS; c++) begin
      if (client_rq[c] && (3'(c) >= ptr_q) && !hi_found) begin
        hi_found = 1'b1;
        hi_win   = 3'(c);
      end
      if (client_rq[c] && !lo_found) begin
        lo_found = 1'b1;
        lo_win   = 3'(c);
      end
    end
    winner = hi_found ? hi_win : lo_win;
  end

  always_comb begin
    sel_addr = '0;
    sel_wr   = 1'b0;
    sel_data = '0;
    for (int c = 0; c < NR_OF_CLIENTS; c++) begin
      if (grant_id_q == 3'(c)) begin
        sel_addr = client_address[c*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wr   = client_wr_ni[c];
        sel_data = client_dataW[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign rot_ptr = (grant_id_q == LAST_CLIENT) ? 3'd0 : grant_id_q + 3'd1;

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    credit_d   = credit_q;
    timer_d    = timer_q;
    done       = 1'b0;
    timeout    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|client_rq) begin
          state_d    = GRANT;
          grant_id_d = winner;
          timer_d    = '0;
        end
      end
      GRANT: begin
        if (server_ack) begin
          done = 1'b1;
        end else if (timer_q == TIMEOUT_LAST) begin
          done    = 1'b1;
          timeout = 1'b1;
        end else begin
          timer_d = timer_q + 8'd1;
        end
        // The pointer client spends one credit per completion; anyone else forces rotation.
        if (done) begin
          state_d = IDLE;
          if ((grant_id_q == ptr_q) && (credit_q > 4'd1)) begin
            credit_d = credit_q - 4'd1;
          end else begin
            ptr_d    = rot_ptr;
            credit_d = weight_of(rot_ptr);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      ptr_q      <= '0;
      credit_q   <= weight_of(3'd0);
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
      credit_q   <= credit_d;
      timer_q    <= timer_d;
    end
  end

  always_comb begin
    server_rq      = 1'b0;
    busy           = 1'b0;
    server_address = '0;
    server_wr_ni   = 1'b0;
    server_dataW   = '0;
    client_dataR   = '0;
    client_ack     = '0;
    client_err     = '0;
    if (state_q == GRANT) begin
      server_rq      = 1'b1;
      busy           = 1'b1;
      server_address = sel_addr;
      server_wr_ni   = sel_wr;
      server_dataW   = sel_data;
      client_dataR   = timeout ? '0 : server_dataR;
      for (int c = 0; c < NR_OF_CLIENTS; c++) begin
        if (grant_id_q == 3'(c)) begin
          client_ack[c] = done;
          client_err[c] = timeout;
        end
      end
    end
  end

  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_weighted_bus_arbiter.sv
// Bench for weighted_bus_arbiter: random clients and a random-latency RAM responder, checked
// against a transaction-level arbitration model through an expected-ack queue.
module tb_weighted_bus_arbiter;

  localparam int          N   = 4;
  localparam int          DW  = 8;
  localparam int          AW  = 4;
  localparam int          TO  = 15;
  localparam logic [31:0] WTS = 32'h0000_4201;  // client 1 weight 0 behaves as 1
  localparam int          EW  = N + 2 + DW;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    client_rq = '0;
  logic [N*AW-1:0] client_address = '0;
  logic [N-1:0]    client_wr_ni = '0;
  logic [N*DW-1:0] client_dataW = '0;
  logic [N-1:0]    client_ack, client_err;
  logic [DW-1:0]   client_dataR, server_dataW, server_dataR;
  logic [AW-1:0]   server_address;
  logic            server_rq, server_wr_ni, busy;
  logic            server_ack = 1'b0;
  logic [2:0]      grant_id;

  weighted_bus_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NR_OF_CLIENTS(N),
    .CLIENT_WEIGHTS(WTS), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .client_rq(client_rq), .client_address(client_address),
    .client_wr_ni(client_wr_ni), .client_dataW(client_dataW),
    .client_ack(client_ack), .client_err(client_err), .client_dataR(client_dataR),
    .server_address(server_address), .server_rq(server_rq),
    .server_wr_ni(server_wr_ni), .server_dataW(server_dataW),
    .server_ack(server_ack), .server_dataR(server_dataR),
    .grant_id(grant_id), .busy(busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];
  logic [2:0]    grant_log[$];
  int            gap[N];
  int            ram_mode = 0;
  logic [DW-1:0] ram[16];
  logic [DW-1:0] shadow[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int wt(input int i);
    int w;
    w = int'((WTS >> (4 * i)) & 32'hF);
    return (w == 0) ? 1 : w;
  endfunction

  // ---------------- RAM responder ----------------
  assign server_dataR = ram[server_address];

  initial begin : ram_resp
    int cnt, dly;
    cnt = 0;
    dly = 0;
    forever begin
      @(posedge clk); #1;
      if (!reset) begin
        server_ack = 1'b0;
        cnt = 0;
      end else if (server_ack) begin
        server_ack = 1'b0;
        cnt = 0;
      end else if (server_rq) begin
        if (cnt == 0) begin
          case (ram_mode)
            0: dly = 1;
            2: dly = 255;
            3: case ($urandom_range(0, 9))
                 0: dly = 13;
                 1: dly = 14;
                 2: dly = 15;
                 3: dly = 40;
                 default: dly = int'($urandom_range(0, 3));
               endcase
            default: dly = int'($urandom_range(0, 3));
          endcase
        end
        if (cnt == dly) server_ack = 1'b1;
        else cnt++;
      end else begin
        cnt = 0;
        server_ack = (ram_mode == 3) && ($urandom_range(0, 5) == 0);
      end
    end
  end

  initial begin : ram_write
    forever begin
      @(negedge clk);
      if (reset && server_ack && server_rq && server_wr_ni) ram[server_address] = server_dataW;
    end
  end

  // ---------------- reference model ----------------
  // Tracks the owner, its GRANT age and the weighted pointer/credit; pushes one expected ack
  // record per predicted completion and checks forwarding every cycle.
  initial begin : ref_model
    int m_owner, m_timer, m_ptr, m_credit, c;
    logic [AW-1:0] a;
    logic          w, err, chk;
    logic [DW-1:0] d, rdat;
    logic [N-1:0]  e_ack;
    m_owner = -1; m_timer = 0; m_ptr = 0; m_credit = wt(0);
    forever begin
      @(negedge clk);
      if (!reset) begin
        m_owner = -1; m_timer = 0; m_ptr = 0; m_credit = wt(0);
      end else if (m_owner < 0) begin
        check("idle_server_rq", 32'(server_rq), 0);
        check("idle_busy", 32'(busy), 0);
        for (int j = 0; j < N; j++) begin
          c = (m_ptr + j) % N;
          if (m_owner < 0 && client_rq[c]) m_owner = c;
        end
        m_timer = 0;
      end else begin
        a = client_address[m_owner*AW +: AW];
        w = client_wr_ni[m_owner];
        d = client_dataW[m_owner*DW +: DW];
        check("grant_server_rq", 32'(server_rq), 1);
        check("grant_busy", 32'(busy), 1);
        check("grant_id", 32'(grant_id), 32'(m_owner));
        check("fwd_address", 32'(server_address), 32'(a));
        check("fwd_wr_ni", 32'(server_wr_ni), 32'(w));
        check("fwd_dataW", 32'(server_dataW), 32'(d));
        if (server_ack || m_timer == TO - 1) begin
          err   = !server_ack;
          chk   = err || !w;
          rdat  = err ? '0 : shadow[a];
          e_ack = '0;
          e_ack[m_owner] = 1'b1;
          exp_q.push_back({e_ack, err, chk, rdat});
          if (!err && w) shadow[a] = d;
          if (m_owner == m_ptr && m_credit > 1) m_credit--;
          else begin
            m_ptr = (m_owner + 1) % N;
            m_credit = wt(m_ptr);
          end
          m_owner = -1;
        end else begin
          m_timer++;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [EW-1:0] e;
    logic [N-1:0]  e_ack;
    forever begin
      @(negedge clk); #2;
      if (reset) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          e_ack = e[EW-1 -: N];
          check("ack_onehot", 32'(client_ack), 32'(e_ack));
          check("ack_err", 32'(client_err), e[DW+1] ? 32'(e_ack) : 0);
          if (e[DW]) check("ack_dataR", 32'(client_dataR), 32'(e[DW-1:0]));
        end else begin
          check("no_ack", 32'({client_err, client_ack}), 0);
        end
      end
    end
  end

  initial begin : grant_logger
    logic prev_busy;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (reset && busy && !prev_busy) grant_log.push_back(grant_id);
      prev_busy = reset && busy;
    end
  end

  // ---------------- drivers ----------------
  task automatic run_random(input logic [N-1:0] mask, input int max_gap, input int ncyc);
    logic [N-1:0] seen;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      @(negedge clk);
      seen = client_ack;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (seen[i]) begin
          gap[i] = int'($urandom_range(0, max_gap));
          client_rq[i] = 1'b0;
        end
        if (!client_rq[i] && mask[i]) begin
          if (gap[i] > 0) gap[i]--;
          else begin
            client_rq[i] = 1'b1;
            client_address[i*AW +: AW] = AW'($urandom_range(0, 15));
            client_wr_ni[i] = 1'($urandom_range(0, 1));
            client_dataW[i*DW +: DW] = DW'($urandom_range(0, 255));
          end
        end
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (client_rq != '0 && n < 300) begin
      run_random('0, 0, 1);
      n++;
    end
    check("drain_done", 32'(client_rq), 0);
  endtask

  task automatic do_txn(input int idx, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int lat,
                        output logic [DW-1:0] rdata, output logic err);
    logic got;
    @(posedge clk); #1;
    client_rq[idx] = 1'b1;
    client_wr_ni[idx] = wr;
    client_address[idx*AW +: AW] = a;
    client_dataW[idx*DW +: DW] = d;
    lat = 0; got = 1'b0; rdata = '0; err = 1'b0;
    while (!got && lat < 60) begin
      @(negedge clk);
      lat++;
      if (client_ack[idx]) begin
        got = 1'b1;
        rdata = client_dataR;
        err = client_err[idx];
      end
    end
    check("txn_ack_seen", 32'(got), 1);
    @(posedge clk); #1;
    client_rq[idx] = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    reset = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    reset = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int lat, n;
    logic [DW-1:0] rd;
    logic er;
    logic [2:0] order_b[10];
    order_b = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd0, 3'd1};
    for (int a = 0; a < 16; a++) begin
      ram[a] = '0;
      shadow[a] = '0;
    end
    for (int i = 0; i < N; i++) gap[i] = 0;

    #7;
    check("rst_server_rq", 32'(server_rq), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_client_ack", 32'(client_ack), 0);
    check("rst_client_err", 32'(client_err), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_client_dataR", 32'(client_dataR), 0);
    @(posedge clk); #3;
    reset = 1'b1;

    // single client write then read-back, RAM acks one cycle after server_rq
    ram_mode = 0;
    do_txn(2, 1'b1, 4'd6, 8'h5A, lat, rd, er);
    check("a_wr_latency", 32'(lat), 3);
    check("a_wr_err", 32'(er), 0);
    do_txn(2, 1'b0, 4'd6, 8'h00, lat, rd, er);
    check("a_rd_latency", 32'(lat), 3);
    check("a_rd_data", 32'(rd), 32'h5A);
    check("a_rd_err", 32'(er), 0);

    // all four requesting back-to-back from a fresh pointer
    do_reset();
    grant_log.delete();
    run_random(4'hF, 0, 60);
    drain();
    check("b_grant_count", 32'(grant_log.size() >= 10), 1);
    for (int k = 0; k < 10; k++)
      if (k < grant_log.size()) check("b_grant_order", 32'(grant_log[k]), 32'(order_b[k]));

    // sparse requesters 1 and 3
    do_reset();
    run_random(4'b1010, 0, 50);
    drain();

    // watchdog: server never acks
    ram_mode = 2;
    do_txn(0, 1'b0, 4'd3, 8'h00, lat, rd, er);
    check("d_timeout_latency", 32'(lat), TO + 1);
    check("d_timeout_err", 32'(er), 1);
    check("d_timeout_dataR", 32'(rd), 0);
    run_random(4'b0011, 2, 80);
    drain();

    // asynchronous reset in GRANT cycle 3 of client 2
    @(posedge clk); #1;
    client_wr_ni[2] = 1'b1;
    client_address[2*AW +: AW] = 4'h9;
    client_dataW[2*DW +: DW] = 8'hC3;
    client_rq[2] = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    check("e_busy_before", 32'(busy), 1);
    check("e_gid_before", 32'(grant_id), 2);
    reset = 1'b0;
    #1;
    check("e_rst_server_rq", 32'(server_rq), 0);
    check("e_rst_busy", 32'(busy), 0);
    check("e_rst_ack", 32'(client_ack), 0);
    check("e_rst_gid", 32'(grant_id), 0);
    client_wr_ni[3] = 1'b0;
    client_address[3*AW +: AW] = 4'h9;
    client_rq[3] = 1'b1;
    @(posedge clk);
    @(posedge clk); #3;
    reset = 1'b1;
    ram_mode = 1;
    n = 0;
    while (!busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("e_first_grant_busy", 32'(busy), 1);
    check("e_first_grant_id", 32'(grant_id), 2);
    drain();

    // long random mix: random latencies, boundary delays, timeouts, stray acks
    ram_mode = 3;
    run_random(4'hF, 4, 1500);
    ram_mode = 1;
    drain();
    repeat (3) @(posedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
